// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the transmitter) and frame configuration.
package uart_pkg;

  typedef enum logic [2:0] {
    SM_IDLE      = 3'd0,
    SM_RX_START  = 3'd1,
    SM_RX_DATA   = 3'd2,
    SM_RX_PARITY = 3'd3,
    SM_RX_STOP   = 3'd4
  } uart_state_e;

  typedef struct packed {
    logic [3:0] data_bits;
    logic [3:0] parity_bits;
    logic [3:0] stop_bits;
  } uart_frame_cfg_t;

  function automatic uart_frame_cfg_t make_frame_cfg(input int data_bits, input int parity_bits,
                                                     input int stop_bits);
    uart_frame_cfg_t cfg;
    cfg.data_bits   = 4'(data_bits);
    cfg.parity_bits = 4'(parity_bits);
    cfg.stop_bits   = 4'(stop_bits);
    return cfg;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a configurable reset value.
module uart_sync2 #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB-first, one-cycle data_valid pulse with error flags.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BIT_COUNT = 8,
  parameter int STOP_BIT_COUNT = 1,
  parameter int CLK_PER_BIT    = 8,
  parameter int PARITY_ODD     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      serial,
  output logic [DATA_BIT_COUNT-1:0] data,
  output logic                      data_valid,
  output logic                      framing_error,
  output logic                      parity_error,
  output logic [2:0]                dbg_state_o
);

  localparam int CW = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam uart_frame_cfg_t FRAME_CFG = make_frame_cfg(DATA_BIT_COUNT, PAR_BITS, STOP_BIT_COUNT);
  localparam logic [3:0] DATA_LAST = FRAME_CFG.data_bits - 4'd1;
  localparam logic [3:0] STOP_LAST = FRAME_CFG.stop_bits - 4'd1;

  logic serial_s;

  uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .async_i(serial),
    .sync_o (serial_s)
  );

  uart_state_e               state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [3:0]                idx_q, idx_d;
  logic [DATA_BIT_COUNT-1:0] shift_q, shift_d;
  logic                      ferr_acc_q, ferr_acc_d;
  logic [DATA_BIT_COUNT-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
  logic                      par_q, par_d;
  logic                      pe_q, pe_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SM_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      pe_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      pe_q       <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    ferr_acc_d = ferr_acc_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    fe_d       = fe_q;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    pe_d       = pe_q;
`endif
    unique case (state_q)
      SM_IDLE: begin
        if (!serial_s) begin
          state_d = SM_RX_START;
          cnt_d   = '0;
        end
      end
      SM_RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          idx_d      = '0;
          ferr_acc_d = 1'b0;
          state_d    = serial_s ? SM_IDLE : SM_RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SM_RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          // Shifting in from the top leaves the first bit received at the LSB.
          shift_d = {serial_s, shift_q[DATA_BIT_COUNT-1:1]};
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = SM_RX_PARITY;
`else
            state_d = SM_RX_STOP;
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SM_RX_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = serial_s;
          state_d = SM_RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = SM_IDLE;
`endif
      end
      SM_RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            // Leave at mid-stop so a start bit right behind it is not missed.
            state_d = SM_IDLE;
            idx_d   = '0;
            valid_d = 1'b1;
            data_d  = shift_q;
            fe_d    = ferr_acc_q | ~serial_s;
`ifdef UART_RX_PARITY_EN
            pe_d    = ((^shift_q) ^ par_q) != 1'(PARITY_ODD);
`endif
          end else begin
            idx_d      = idx_q + 4'd1;
            ferr_acc_d = ferr_acc_q | ~serial_s;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = SM_IDLE;
    endcase
  end

  assign data          = data_q;
  assign data_valid    = valid_q;
  assign framing_error = fe_q;
  assign dbg_state_o   = state_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = pe_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_PER_BIT = 8, 8 data bits, 1 stop bit, even parity when enabled.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 8;
  localparam int DBC = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // E0 -> stop sample: half a bit, then start, data and parity periods.
  localparam int STOP_OFS = CPB / 2 + (DBC + 1 + PAR_BITS) * CPB;
  // Line driven at a negedge is seen by the FSM on the third rising edge.
  localparam int LAT = 3 + STOP_OFS;
  // Two back-to-back break frames of STOP_OFS+1 cycles each, released before a third can start.
  localparam int BRK_LEN = 2 * (STOP_OFS + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           serial = 1'b1;
  logic [DBC-1:0] data;
  logic           data_valid;
  logic           framing_error;
  logic           parity_error;
  logic [2:0]     dbg_state;

  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  int         got_cyc_q[$];
  int         cyc = 0;
  int         dbl_pulse = 0;
  logic       prev_valid = 1'b0;
  int         n_vec = 0;
  int         n_bad = 0;

  uart_rx #(
    .DATA_BIT_COUNT(DBC),
    .STOP_BIT_COUNT(1),
    .CLK_PER_BIT   (CPB),
    .PARITY_ODD    (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .serial       (serial),
    .data         (data),
    .data_valid   (data_valid),
    .framing_error(framing_error),
    .parity_error (parity_error),
    .dbg_state_o  (dbg_state)
  );

  // Clock and cycle stamp
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Capture every delivered word as {framing, parity, data}
  always @(negedge clk) begin
    if (data_valid) begin
      got_q.push_back({framing_error, parity_error, data});
      got_cyc_q.push_back(cyc);
      if (prev_valid) dbl_pulse++;
    end
    prev_valid = data_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b);
    serial = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < DBC; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
    serial = 1'b1;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic clear_scoreboard();
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
    dbl_pulse = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    serial = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", data); end
    n_vec++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    n_vec++; if (framing_error !== 1'b0) begin n_bad++; $display("FAIL reset_fe: got %b want 0", framing_error); end
    n_vec++; if (parity_error !== 1'b0) begin n_bad++; $display("FAIL reset_pe: got %b want 0", parity_error); end
    n_vec++; if (dbg_state !== 3'(SM_IDLE)) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, SM_IDLE); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++; if (dbg_state !== 3'(SM_IDLE)) begin n_bad++; $display("FAIL idle_after_reset: got %0d want %0d", dbg_state, SM_IDLE); end
  endtask

  task automatic test_basic();
    bit ok;
    int c0;
    logic [9:0] exp, got;
    clear_scoreboard();
    exp_q.push_back({2'b00, 8'hA5});
    c0 = cyc;
    send_frame(8'hA5, ^8'hA5, 1'b1);
    wait_frames(1, 4 * CPB, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL basic_arrival: got %0d frames want 1", got_q.size()); end
    if (ok) begin
      exp = exp_q.pop_front();
      got = got_q.pop_front();
      n_vec++; if (got !== exp) begin n_bad++; $display("FAIL basic_word: got %h want %h", got, exp); end
      n_vec++; if (got_cyc_q[0] - c0 !== LAT) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", got_cyc_q[0] - c0, LAT); end
    end
    repeat (2 * CPB) @(negedge clk);
    n_vec++; if (dbl_pulse !== 0) begin n_bad++; $display("FAIL basic_pulse_width: got %0d extra cycles want 0", dbl_pulse); end
    n_vec++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_drop: got %b want 0", data_valid); end
    n_vec++; if (data !== 8'hA5) begin n_bad++; $display("FAIL basic_data_hold: got %h want a5", data); end
  endtask

  task automatic test_glitch();
    bit ok;
    logic [9:0] exp, got;
    clear_scoreboard();
    serial = 1'b0;
    repeat (3) @(negedge clk);
    serial = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_vec++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL glitch_no_pulse: got %0d frames want 0", got_q.size()); end
    n_vec++; if (dbg_state !== 3'(SM_IDLE)) begin n_bad++; $display("FAIL glitch_state: got %0d want %0d", dbg_state, SM_IDLE); end
    exp_q.push_back({2'b00, 8'h3C});
    send_frame(8'h3C, ^8'h3C, 1'b1);
    wait_frames(1, 4 * CPB, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL glitch_next_arrival: got %0d frames want 1", got_q.size()); end
    if (ok) begin
      exp = exp_q.pop_front();
      got = got_q.pop_front();
      n_vec++; if (got !== exp) begin n_bad++; $display("FAIL glitch_next_word: got %h want %h", got, exp); end
    end
  endtask

  task automatic test_framing();
    bit ok;
    logic [9:0] exp, got;
    clear_scoreboard();
    exp_q.push_back({2'b10, 8'h81});
    send_frame(8'h81, ^8'h81, 1'b0);
    wait_frames(1, 4 * CPB, ok);
    repeat (3 * CPB) @(negedge clk);
    n_vec++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL framing_count: got %0d frames want 1", got_q.size()); end
    if (ok) begin
      exp = exp_q.pop_front();
      got = got_q.pop_front();
      n_vec++; if (got !== exp) begin n_bad++; $display("FAIL framing_word: got %h want %h", got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] vals[3];
    logic [9:0] exp, got;
    vals = '{8'h00, 8'hFF, 8'h55};
    clear_scoreboard();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'b00, vals[i]});
      send_frame(vals[i], ^vals[i], 1'b1);
    end
    wait_frames(3, 4 * CPB, ok);
    repeat (2 * CPB) @(negedge clk);
    n_vec++; if (got_q.size() !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d frames want 3", got_q.size()); end
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        exp = exp_q.pop_front();
        got = got_q.pop_front();
        n_vec++; if (got !== exp) begin n_bad++; $display("FAIL b2b_word%0d: got %h want %h", i, got, exp); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [7:0] d;
    logic [9:0] exp, got;
    d = 8'hF0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_scoreboard();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    serial = d[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (CPB / 2 - 1) @(negedge clk);
    for (int i = 5; i < DBC; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(1'b1);
    repeat (2 * CPB) @(negedge clk);
    n_vec++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL rstmid_no_pulse: got %0d frames want 0", got_q.size()); end
    n_vec++; if (data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", data); end
    exp_q.push_back({2'b00, 8'h0F});
    send_frame(8'h0F, ^8'h0F, 1'b1);
    wait_frames(1, 4 * CPB, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL rstmid_next_arrival: got %0d frames want 1", got_q.size()); end
    if (ok) begin
      exp = exp_q.pop_front();
      got = got_q.pop_front();
      n_vec++; if (got !== exp) begin n_bad++; $display("FAIL rstmid_next_word: got %h want %h", got, exp); end
    end
  endtask

  task automatic test_break();
    logic [9:0] exp, got;
    clear_scoreboard();
    exp_q.push_back({2'b10, 8'h00});
    exp_q.push_back({2'b10, 8'h00});
    serial = 1'b0;
    repeat (BRK_LEN) @(negedge clk);
    serial = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    n_vec++; if (got_q.size() !== 2) begin n_bad++; $display("FAIL break_count: got %0d frames want 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      for (int i = 0; i < 2; i++) begin
        exp = exp_q.pop_front();
        got = got_q.pop_front();
        n_vec++; if (got !== exp) begin n_bad++; $display("FAIL break_word%0d: got %h want %h", i, got, exp); end
      end
    end
    n_vec++; if (dbg_state !== 3'(SM_IDLE)) begin n_bad++; $display("FAIL break_idle: got %0d want %0d", dbg_state, SM_IDLE); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    bit ok;
    logic [9:0] exp, got;
    clear_scoreboard();
    exp_q.push_back({2'b01, 8'h07});
    exp_q.push_back({2'b00, 8'h07});
    send_frame(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_frames(2, 4 * CPB, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL parity_arrival: got %0d frames want 2", got_q.size()); end
    if (ok) begin
      for (int i = 0; i < 2; i++) begin
        exp = exp_q.pop_front();
        got = got_q.pop_front();
        n_vec++; if (got !== exp) begin n_bad++; $display("FAIL parity_word%0d: got %h want %h", i, got, exp); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver and companion to the transmitter: recovers frames from an asynchronous serial line, LSB-first, idle-high.
- Frame: 1 start bit, DATA_BIT_COUNT data bits, optional parity bit, STOP_BIT_COUNT stop bits.
- Samples each bit at its midpoint, using the same CLK_PER_BIT bit period as the transmitter.
- Delivers each byte as a one-cycle valid pulse with error flags, for the console-mux datapath.

## Interface
- DATA_BIT_COUNT, 8, data bits per frame, 5..9
- STOP_BIT_COUNT, 1, stop bits checked, 1..2
- CLK_PER_BIT, 8, clk cycles per bit, even, >= 4
- PARITY_ODD, 0, 1 = odd parity, 0 = even; used only when UART_RX_PARITY_EN is defined

- clk  input  1  sole clock
- rst  input  1  synchronous, active-high reset
- serial  input  1  asynchronous line, idle high
- data  output  DATA_BIT_COUNT  last received word; holds until the next frame completes
- data_valid  output  1  one-cycle pulse when a frame completes
- framing_error  output  1  qualified by data_valid: a stop bit was sampled low
- parity_error  output  1  qualified by data_valid: parity mismatch

## Operation
- serial passes through a 2-flop synchronizer, producing serial_s. It is reset to 1.
- All decisions below use serial_s only.
- States: SM_IDLE, SM_RX_START, SM_RX_DATA, SM_RX_PARITY, SM_RX_STOP.
- SM_IDLE
  - serial_s == 0 moves to SM_RX_START with clock_count = 0.
- SM_RX_START
  - Counts to CLK_PER_BIT/2-1, then samples serial_s.
  - Sample 0: go to SM_RX_DATA with clock_count = 0 and bit index 0.
  - Sample 1: treat as a glitch and return to SM_IDLE. No pulse.
- SM_RX_DATA
  - Every CLK_PER_BIT cycles, shift serial_s into bit index i, LSB first.
  - After bit DATA_BIT_COUNT-1, go to SM_RX_PARITY if the macro is defined, else to SM_RX_STOP.
- SM_RX_PARITY
  - One bit period, then sample.
  - parity_error = XOR(data bits, sampled bit) != PARITY_ODD.
- SM_RX_STOP
  - Samples STOP_BIT_COUNT stop bits, one bit period apart.
  - Any sample of 0 sets framing_error.
  - After the final stop sample: go to SM_IDLE, pulse data_valid, update data and both error flags.
- Frames with errors still deliver data and data_valid. The downstream block decides whether to discard.
- Returning to SM_IDLE at the middle of the final stop bit is required. It lets back-to-back frames be received with no gap.
- Counter width: $clog2(CLK_PER_BIT)+1 bits. Bit index: 4 bits.

## Timing
- Reset values:
  - data = 0, data_valid = 0, framing_error = 0, parity_error = 0.
  - State SM_IDLE, counters 0, synchronizer flops 1.
- Let E0 be the clk edge at which serial_s is first seen low in SM_IDLE.
  - Start is sampled at E0 + CLK_PER_BIT/2.
  - Data bit k is sampled at E0 + CLK_PER_BIT/2 + (k+1)*CLK_PER_BIT.
- Latency: data_valid is high in the cycle after the final stop sample edge. data and the error flags become valid in that same cycle.
- Line-to-E0 delay is 2 or 3 clk cycles because of the synchronizer.
- rst mid-frame takes effect on the next edge: abandon the frame, no data_valid, data keeps its reset value of 0.
- If serial_s is low in the cycle SM_STOP returns to SM_IDLE, the new start is detected on the following edge. No frame is lost.
- serial held low forever (break condition):
  - Each frame completes with framing_error = 1 and data = 0.
  - The receiver then re-enters SM_RX_START.

## Configuration
- UART_RX_PARITY_EN defined:
  - A parity bit is expected between the data and stop bits.
  - SM_RX_PARITY is used and checked per PARITY_ODD.
- UART_RX_PARITY_EN undefined:
  - No parity bit is expected and SM_RX_PARITY is unreachable.
  - parity_error is tied to 0.
  - PARITY_ODD is ignored.

## Structure
- Shared package uart_pkg holds:
  - the state encoding constants (3-bit: SM_IDLE..SM_RX_STOP), shared with the transmitter;
  - a frame-config typedef (data, parity, stop counts).
- Sub-module uart_sync2: 2-flop synchronizer with a reset value parameter (default 1). Reusable for other asynchronous inputs.

## Test plan
All scenarios use CLK_PER_BIT = 8 and 8N1 unless stated.
- Send 0xA5 -> data = 0xA5, data_valid = 1 for exactly 1 cycle, both error flags 0, pulse at bit time 9.5 after the start edge.
- 3-cycle low glitch on an idle line -> no data_valid, state back to SM_IDLE, next frame 0x3C received correctly.
- Frame 0x81 with the stop bit driven low -> data = 0x81, framing_error = 1 with data_valid.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three pulses in order with the correct values and no errors.
- rst asserted during data bit 4 of 0xF0, then 0x0F sent -> no pulse for 0xF0; 0x0F received cleanly.
- With UART_RX_PARITY_EN and PARITY_ODD = 0, send 0x07 with parity bit 0 -> parity_error = 1. With parity bit 1 -> parity_error = 0.
